// File: rtl/adder_bist_pkg.sv
// rtl/adder_bist_pkg.sv - shared types and constants for the adder BIST checker
package adder_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DIRECTED,
        ST_RANDOM,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam int          DIRECTED_COUNT = 4;
    localparam int          MISMATCH_W     = 8;
    // x^16+x^14+x^13+x^11+1 as a right-shifting Fibonacci register: taps on bits 0,2,3,5
    localparam logic [15:0] LFSR_TAPS      = 16'h002D;

    // Returns {b, a} in two byte lanes; max is 2^width-1.
    function automatic logic [15:0] directed_vector(input logic [1:0] idx, input int unsigned width);
        logic [7:0] mx;
        mx = 8'((1 << width) - 1);
        case (idx)
            2'd0:    return 16'h0000;
            2'd1:    return {8'd10, 8'd5};
            2'd2:    return {mx, mx};
            default: return {8'd1, mx};
        endcase
    endfunction

endpackage

// File: rtl/adder_bist_lfsr.sv
// rtl/adder_bist_lfsr.sv - 16-bit Fibonacci LFSR with seed, load and advance
module adder_bist_lfsr
    import adder_bist_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic        advance,
    output logic [15:0] state
);

    always_ff @(posedge clock) begin
        if (reset || load) begin
            state <= SEED;
        end else if (advance) begin
            state <= {^(state & LFSR_TAPS), state[15:1]};
        end
    end

endmodule

// File: rtl/adder_bist_checker.sv
// rtl/adder_bist_checker.sv - adder stimulus/response BIST engine (option: ADDER_BIST_FAIL_CAPTURE_EN)
module adder_bist_checker
    import adder_bist_pkg::*;
#(
    parameter int          WIDTH       = 4,
    parameter int          NUM_RANDOM  = 16,
    parameter int          DUT_LATENCY = 1,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    output logic [WIDTH-1:0]      a,
    output logic [WIDTH-1:0]      b,
    input  logic [WIDTH:0]        sum,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [MISMATCH_W-1:0] mismatch_count,
    output logic [WIDTH-1:0]      fail_a,
    output logic [WIDTH-1:0]      fail_b,
    output logic [WIDTH:0]        fail_sum
);

    localparam int DEPTH = DUT_LATENCY + 1;

    state_t                state, state_n;
    logic [7:0]            cnt, cnt_n;
    logic                  issue, lfsr_adv, clr;
    logic [WIDTH-1:0]      va, vb;
    logic [15:0]           dv, lfsr;
    logic [MISMATCH_W-1:0] mm_n;
    logic                  chk_fail;
    logic                  exp_vld [DEPTH];
    logic [WIDTH:0]        exp_sum [DEPTH];
    logic                  unused_bits;

    adder_bist_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clock   (clock),
        .reset   (reset),
        .load    (1'b0),
        .advance (lfsr_adv),
        .state   (lfsr)
    );

    assign unused_bits = ^{lfsr, dv};

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        issue    = 1'b0;
        lfsr_adv = 1'b0;
        clr      = 1'b0;
        dv       = directed_vector(cnt[1:0], WIDTH);
        va       = WIDTH'(dv[7:0]);
        vb       = WIDTH'(dv[15:8]);
        case (state)
            ST_IDLE, ST_DONE: begin
                // cnt is zero here, so dv already holds directed vector 0
                if (start) begin
                    issue   = 1'b1;
                    clr     = 1'b1;
                    cnt_n   = 8'd1;
                    state_n = ST_DIRECTED;
                end
            end
            ST_DIRECTED: begin
                issue = 1'b1;
                if (cnt == 8'(DIRECTED_COUNT - 1)) begin
                    cnt_n   = '0;
                    state_n = ST_RANDOM;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            ST_RANDOM: begin
                issue    = 1'b1;
                lfsr_adv = 1'b1;
                va       = lfsr[WIDTH-1:0];
                vb       = lfsr[2*WIDTH-1:WIDTH];
                if (cnt == 8'(NUM_RANDOM - 1)) begin
                    cnt_n   = '0;
                    state_n = ST_DRAIN;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            ST_DRAIN: begin
                // covers the expected pipeline plus the compare stage
                if (cnt == 8'(DUT_LATENCY + 1)) begin
                    cnt_n   = '0;
                    state_n = ST_DONE;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign busy = (state == ST_DIRECTED) || (state == ST_RANDOM) || (state == ST_DRAIN);
    assign done = (state == ST_DONE);

    always_ff @(posedge clock) begin
        if (reset) begin
            a <= '0;
            b <= '0;
        end else if (issue) begin
            a <= va;
            b <= vb;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                exp_vld[i] <= 1'b0;
                exp_sum[i] <= '0;
            end
            chk_fail <= 1'b0;
        end else begin
            exp_vld[0] <= issue;
            exp_sum[0] <= {1'b0, va} + {1'b0, vb};
            for (int i = 1; i < DEPTH; i++) begin
                exp_vld[i] <= exp_vld[i-1];
                exp_sum[i] <= exp_sum[i-1];
            end
            chk_fail <= exp_vld[DEPTH-1] && (sum != exp_sum[DEPTH-1]);
        end
    end

    always_comb begin
        mm_n = mismatch_count;
        if (clr) begin
            mm_n = '0;
        end else if (chk_fail && (mismatch_count != '1)) begin
            mm_n = mismatch_count + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mismatch_count <= '0;
            pass           <= 1'b0;
        end else begin
            mismatch_count <= mm_n;
            if (clr) begin
                pass <= 1'b0;
            end else if ((state == ST_DRAIN) && (state_n == ST_DONE)) begin
                pass <= (mm_n == '0);
            end
        end
    end

`ifdef ADDER_BIST_FAIL_CAPTURE_EN
    logic [WIDTH-1:0] exp_a [DEPTH];
    logic [WIDTH-1:0] exp_b [DEPTH];
    logic [WIDTH-1:0] chk_a, chk_b;
    logic [WIDTH:0]   chk_sum;
    logic             have_fail;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                exp_a[i] <= '0;
                exp_b[i] <= '0;
            end
            chk_a   <= '0;
            chk_b   <= '0;
            chk_sum <= '0;
        end else begin
            exp_a[0] <= va;
            exp_b[0] <= vb;
            for (int i = 1; i < DEPTH; i++) begin
                exp_a[i] <= exp_a[i-1];
                exp_b[i] <= exp_b[i-1];
            end
            chk_a   <= exp_a[DEPTH-1];
            chk_b   <= exp_b[DEPTH-1];
            chk_sum <= sum;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || clr) begin
            fail_a    <= '0;
            fail_b    <= '0;
            fail_sum  <= '0;
            have_fail <= 1'b0;
        end else if (chk_fail && !have_fail) begin
            fail_a    <= chk_a;
            fail_b    <= chk_b;
            fail_sum  <= chk_sum;
            have_fail <= 1'b1;
        end
    end
`else
    assign fail_a   = '0;
    assign fail_b   = '0;
    assign fail_sum = '0;
`endif

endmodule

// File: doc/adder_bist_checker.md
# adder_bist_checker

Synthesizable stimulus/response engine for the other end of the adder interface: it drives operands `a`/`b` into a WIDTH-bit adder DUT, samples its `sum`, and checks each result against an internally computed expectation. It replaces the simulation-only directed/random bench with hardware that can run on the FPGA next to the DUT. It reports pass/fail, a mismatch count and, optionally, the first failing vector.

## Interface
- WIDTH, 4, operand width; 2*WIDTH <= 16
- NUM_RANDOM, 16, random vectors after the directed set; 1..255
- DUT_LATENCY, 1, clock edges from operand change to valid `sum`; 0 means combinational DUT
- LFSR_SEED, 16'hACE1, nonzero LFSR seed
- clock  in  1  single clock, all logic on posedge
- reset  in  1  synchronous, active-high
- start  in  1  begin run; sampled only in IDLE or DONE
- a  out  WIDTH  operand to DUT, registered
- b  out  WIDTH  operand to DUT, registered
- sum  in  WIDTH+1  DUT result
- busy  out  1  run in progress
- done  out  1  run complete; held until next start or reset
- pass  out  1  valid when done=1; 1 iff mismatch_count==0
- mismatch_count  out  8  failures counted, saturates at 255
- fail_a, fail_b  out  WIDTH  first failing operands
- fail_sum  out  WIDTH+1  first failing DUT sum

## Operation
- Reset values: a=0, b=0, busy=0, done=0, pass=0, mismatch_count=0, fail_*=0, LFSR=LFSR_SEED, state IDLE.
- States:
  - IDLE: wait for start=1, then go to DIRECTED.
  - DIRECTED: drive 4 vectors, one per cycle: (0,0), (5,10), (max,max), (max,1), with max = 2^WIDTH-1. Then go to RANDOM.
  - RANDOM: drive NUM_RANDOM vectors, one per cycle, with a=lfsr[WIDTH-1:0] and b=lfsr[2*WIDTH-1:WIDTH]. The LFSR advances once per random vector.
  - DRAIN: wait DUT_LATENCY+1 cycles so the last result is checked, then go to DONE.
  - DONE: done=1 and busy=0. start=1 clears done/pass/count/fail_* and returns to DIRECTED. The LFSR is not reseeded, so a rerun uses a fresh sequence.
- LFSR: 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1.
- Expected value: a+b, zero-extended to WIDTH+1 bits. No truncation.
- A vector is counted as failing when sampled sum != expected. On a failure, mismatch_count increments (saturating at 255).
- start is ignored while busy=1.
- Reset at any point, including mid-run or during DRAIN, aborts the run and restores all reset values within one edge.
- After the operands return to idle, a and b hold their last driven values.

## Timing
- start is sampled at edge E0. The first vector appears on a/b after E0, and busy=1 after E0.
- Vector k (0-based) is driven after edge E0+k.
- Its sum is sampled at edge E0+k+DUT_LATENCY+1.
- Expected values travel through a valid-tagged shift pipeline of depth DUT_LATENCY+1.
- Total run length is N=4+NUM_RANDOM vectors. done=1 and busy=0 after edge E0+N+DUT_LATENCY+1.
- pass and mismatch_count update on the same edge as done rises.
- A failure on the last vector is reflected on that same edge.

## Configuration
- With `ADDER_BIST_FAIL_CAPTURE_EN` defined:
  - fail_a, fail_b and fail_sum latch the operands and sum of the first mismatch in a run.
  - They hold until the next start or reset.
  - The captured operands travel with the expected pipeline.
- Without the macro:
  - The ports are present but tied to 0.
  - No capture registers are built.

## Structure
- Package `adder_bist_pkg` holds:
  - the state enum (IDLE, DIRECTED, RANDOM, DRAIN, DONE)
  - the directed-vector count (4)
  - the LFSR tap mask
  - the mismatch-counter width (8)
- Sub-module `adder_bist_lfsr` is a 16-bit LFSR with seed parameter, load and advance inputs, and state output.

## Test plan
- Correct registered adder, DUT_LATENCY=1, WIDTH=4: start pulse → vectors (0,0), (5,10), (15,15), (15,1), then 16 random; done=1 at E0+22, pass=1, mismatch_count=0.
- Adder with stuck-at-0 sum[4]: vector (15,15) expects 30 but sees 14 → mismatch counted; macro defined gives fail_a=15, fail_b=15, fail_sum=14; pass=0.
- DUT_LATENCY=0 with a combinational adder: no false mismatches, and done=1 at E0+21.
- Reset asserted during RANDOM: the next edge gives busy=0, done=0, a=b=0, mismatch_count=0; a following start reruns the seeded sequence from the top.
- A DUT that always fails with NUM_RANDOM=255: mismatch_count saturates at 255 and does not wrap.
- start held high throughout the run: ignored while busy; a rerun begins on the edge after DONE is entered.
